block_link_tx: RTL and testbench
================================

# block_link_tx

Parametrised successor of the platform's byte-serial block transmitter. Pops BLK_W-bit blocks from a show-ahead FIFO and drives each block to the chip as BLK_W/BUS_W beats on a BUS_W-bit bus, marking every beat with a shakehand toggle. ACK_MODE=0 is open-loop and paced by the `en` tick. ACK_MODE=1 adds closed-loop acknowledge from the chip, an acknowledge timeout, and block/error counters for the platform scoreboard.

## Interface
- BLK_W, 128, block width; must be a multiple of BUS_W
- BUS_W, 8, data beat width
- ACK_MODE, 0, 0 = open-loop paced by `en`; 1 = wait for chip `ack` after every beat
- TIMEOUT, 1023, cycles to wait in WAIT_ACK before aborting the block (ACK_MODE=1 only); must be ≥1
- clk  in  1  single clock
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  one-cycle pacing tick from the clock-enable divider
- data  in  BLK_W  FIFO head word; valid whenever `empty`=0
- empty  in  1  FIFO empty flag
- require  out  1  one-cycle FIFO pop pulse
- shakehand  out  1  toggles once per issued beat
- tx  out  BUS_W  beat data
- ack  in  1  chip acknowledge toggle; asynchronous; ignored when ACK_MODE=0
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  one-cycle pulse when a block is aborted
- sent_cnt  out  32  number of completed blocks; wraps at 2^32
- err_cnt  out  16  number of aborted blocks; saturates at 16'hFFFF

## Operation
- BEATS = BLK_W/BUS_W. Beats are sent MSB first: beat k = blk[BLK_W-1-k*BUS_W -: BUS_W].
- States: IDLE, SEND, WAIT_ACK.
- IDLE: on an edge with `empty`=0, capture `data` into the block register and clear beat_cnt.
  - `require` is high for exactly the following cycle.
  - Next state is SEND.
- SEND: on an edge with `en`=1, drive `tx` = beat[beat_cnt] and toggle `shakehand`.
  - ACK_MODE=0: if this was the last beat, increment sent_cnt and go to IDLE; otherwise increment beat_cnt and stay in SEND.
  - ACK_MODE=1: clear the timer and go to WAIT_ACK.
- WAIT_ACK: `ack` passes through a 2-flop synchroniser. The beat is accepted when ack_s == shakehand.
  - On accept, if last beat: increment sent_cnt and go to IDLE; otherwise increment beat_cnt and go to SEND.
  - Otherwise the timer increments. When the timer reaches TIMEOUT, pulse `timeout_err`, increment err_cnt (saturating) and go to IDLE.
  - An aborted block is dropped and never re-sent.
  - `tx` and `shakehand` hold their values after an abort.
- Beats are only issued in SEND. An `en` that arrives in IDLE or WAIT_ACK is lost, not queued.
- `tx` and `shakehand` change only when a beat is issued.
- Accept and timeout in the same cycle: accept wins.

## Timing
- Reset values: require=0, shakehand=0, tx=0, busy=0, timeout_err=0, sent_cnt=0, err_cnt=0, state=IDLE, synchroniser flops=0.
- Reset asserted mid-block aborts the block silently: no err_cnt increment and no `require`.
- FIFO not empty to `require` high: 1 cycle.
- First beat is issued on the first `en` edge after entering SEND. `tx`/`shakehand` update on that edge.
- ACK_MODE=0: a block occupies BEATS `en` ticks. Back-to-back blocks add 2 cycles (IDLE capture, then SEND entry).
- ACK_MODE=1: minimum beat period is 3 cycles of synchroniser and compare after the `ack` toggle, plus wait for the next `en`.
- A new block is captured no earlier than 1 cycle after the IDLE re-entry.

## Structure
- Shared package `aes_platform_pkg` holds:
  - the state enum {IDLE, SEND, WAIT_ACK}
  - ACK_OPEN=0 and ACK_CLOSED=1
  - default BLK_W=128 and BUS_W=8
- Sub-module `sync2`: 2-flop synchroniser, synchronous active-low reset to 0, used for `ack`.
- Elaboration check: BLK_W % BUS_W == 0 and TIMEOUT ≥ 1; fail elaboration otherwise.

## Test plan
- ACK_MODE=0, defaults, one block 128'h00112233_44556677_8899AABB_CCDDEEFF, `en` every 250 cycles:
  - 16 beats 00,11,…,FF; `shakehand` toggles 16 times.
  - `require` pulses once; sent_cnt=1; busy falls after beat 16.
- ACK_MODE=0, BLK_W=64, BUS_W=16, three queued blocks:
  - 12 beats total, 4 per block, MSB-first 16-bit words.
  - Exactly 3 `require` pulses; sent_cnt=3.
- ACK_MODE=1, chip model toggles `ack` 5 cycles after each `shakehand` toggle:
  - Full block completes; sent_cnt=1; timeout_err never asserted.
- ACK_MODE=1, TIMEOUT=20, chip stops acknowledging after beat 3:
  - `timeout_err` pulses 20 cycles after entry to WAIT_ACK; err_cnt=1; sent_cnt=0.
  - The next block starts from beat 0.
- `rst_n` low for 1 cycle during beat 7:
  - All outputs return to reset values the next cycle; err_cnt=0.
  - After reset, the next FIFO word transmits normally.
- `en` held high continuously, ACK_MODE=0:
  - Beats issue on consecutive cycles; no beat is skipped or duplicated.

Source files
------------

// File: rtl/aes_platform_pkg.sv
`default_nettype none
// ============================================================================
// aes_platform_pkg : shared types and defaults for the platform block links
// Revision 1.0
// ============================================================================
package aes_platform_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_ACK = 2'd2
  } link_state_t;

  localparam int ACK_OPEN   = 0;
  localparam int ACK_CLOSED = 1;

  localparam int DEF_BLK_W  = 128;
  localparam int DEF_BUS_W  = 8;

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
// sync2 : two-flop synchroniser, synchronous active-low reset to 0
// Revision 1.0
// ============================================================================
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/block_link_tx.sv
`default_nettype none
// ============================================================================
// block_link_tx : pops blocks from a show-ahead FIFO and sends them as beats
// Revision 1.0
// ============================================================================
module block_link_tx
  import aes_platform_pkg::*;
#(
  parameter int BLK_W    = DEF_BLK_W,
  parameter int BUS_W    = DEF_BUS_W,
  parameter int ACK_MODE = ACK_OPEN,
  parameter int TIMEOUT  = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [BLK_W-1:0] data,
  input  logic             empty,
  output logic             require,
  output logic             shakehand,
  output logic [BUS_W-1:0] tx,
  input  logic             ack,
  output logic             busy,
  output logic             timeout_err,
  output logic [31:0]      sent_cnt,
  output logic [15:0]      err_cnt
);

  localparam int BEATS = BLK_W / BUS_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  generate
    if (((BLK_W % BUS_W) != 0) || (TIMEOUT < 1)) begin : g_bad_params
      $error("block_link_tx: BLK_W must be a multiple of BUS_W and TIMEOUT >= 1");
    end
  endgenerate

  link_state_t      state_q, state_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [BUS_W-1:0] tx_q, tx_d;
  logic             shake_q, shake_d;
  logic             require_q, require_d;
  logic             terr_q, terr_d;
  logic [31:0]      sent_q, sent_d;
  logic [15:0]      err_q, err_d;
  logic             ack_s;
  logic             last_beat;

  sync2 u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (ack),
    .q_o   (ack_s)
  );

  assign last_beat = (beat_cnt_q == CNT_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      blk_q      <= '0;
      beat_cnt_q <= '0;
      timer_q    <= '0;
      tx_q       <= '0;
      shake_q    <= 1'b0;
      require_q  <= 1'b0;
      terr_q     <= 1'b0;
      sent_q     <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      beat_cnt_q <= beat_cnt_d;
      timer_q    <= timer_d;
      tx_q       <= tx_d;
      shake_q    <= shake_d;
      require_q  <= require_d;
      terr_q     <= terr_d;
      sent_q     <= sent_d;
      err_q      <= err_d;
    end
  end

  // The block register shifts left per beat, so the outgoing beat is always its top slice.
  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    beat_cnt_d = beat_cnt_q;
    timer_d    = timer_q;
    tx_d       = tx_q;
    shake_d    = shake_q;
    require_d  = 1'b0;
    terr_d     = 1'b0;
    sent_d     = sent_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          blk_d      = data;
          beat_cnt_d = '0;
          require_d  = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (en) begin
          tx_d    = blk_q[BLK_W-1 -: BUS_W];
          shake_d = ~shake_q;
          blk_d   = blk_q << BUS_W;
          if (ACK_MODE == ACK_CLOSED) begin
            timer_d = '0;
            state_d = WAIT_ACK;
          end else if (last_beat) begin
            sent_d  = sent_q + 32'd1;
            state_d = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      WAIT_ACK: begin
        // Accept is checked first so it wins over a coincident timeout.
        if (ack_s == shake_q) begin
          if (last_beat) begin
            sent_d  = sent_q + 32'd1;
            state_d = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
            state_d    = SEND;
          end
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          state_d = IDLE;
          if (err_q != 16'hFFFF) begin
            err_d = err_q + 16'd1;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign require     = require_q;
  assign shakehand   = shake_q;
  assign tx          = tx_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = terr_q;
  assign sent_cnt    = sent_q;
  assign err_cnt     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_block_link_tx.sv
`default_nettype none
// ============================================================================
// tb_block_link_tx : scoreboard bench for block_link_tx (open and closed loop)
// Revision 1.0
// ============================================================================
module tb_block_link_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n  = 1'b0;
  logic rst0_n = 1'b1;
  int   cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // dut0: open loop, 128/8
  logic         en0 = 1'b0, empty0 = 1'b1, ack0 = 1'b0;
  logic [127:0] data0 = '0;
  logic         req0, sh0, busy0, terr0;
  logic [7:0]   tx0;
  logic [31:0]  sent0;
  logic [15:0]  errc0;
  // dut1: closed loop, TIMEOUT=20
  logic         en1 = 1'b1, empty1 = 1'b1, ack1 = 1'b0;
  logic [127:0] data1 = '0;
  logic         req1, sh1, busy1, terr1;
  logic [7:0]   tx1;
  logic [31:0]  sent1;
  logic [15:0]  errc1;
  // dut2: open loop, 64/16
  logic         en2 = 1'b0, empty2 = 1'b1, ack2 = 1'b0;
  logic [63:0]  data2 = '0;
  logic         req2, sh2, busy2, terr2;
  logic [15:0]  tx2;
  logic [31:0]  sent2;
  logic [15:0]  errc2;

  block_link_tx #(.BLK_W(128), .BUS_W(8), .ACK_MODE(0), .TIMEOUT(1023)) u_dut0 (
    .clk(clk), .rst_n(rst_n & rst0_n), .en(en0), .data(data0), .empty(empty0),
    .require(req0), .shakehand(sh0), .tx(tx0), .ack(ack0), .busy(busy0),
    .timeout_err(terr0), .sent_cnt(sent0), .err_cnt(errc0));

  block_link_tx #(.BLK_W(128), .BUS_W(8), .ACK_MODE(1), .TIMEOUT(20)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .data(data1), .empty(empty1),
    .require(req1), .shakehand(sh1), .tx(tx1), .ack(ack1), .busy(busy1),
    .timeout_err(terr1), .sent_cnt(sent1), .err_cnt(errc1));

  block_link_tx #(.BLK_W(64), .BUS_W(16), .ACK_MODE(0), .TIMEOUT(1023)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .data(data2), .empty(empty2),
    .require(req2), .shakehand(sh2), .tx(tx2), .ack(ack2), .busy(busy2),
    .timeout_err(terr2), .sent_cnt(sent2), .err_cnt(errc2));

  logic [127:0] f0[$], f1[$];
  logic [63:0]  f2[$];
  logic [7:0]   e0[$], e1[$];
  logic [15:0]  e2[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push0(input logic [127:0] w, input int nb);
    f0.push_back(w);
    for (int k = 0; k < nb; k++) e0.push_back(w[127 - 8*k -: 8]);
  endtask
  task automatic push1(input logic [127:0] w, input int nb);
    f1.push_back(w);
    for (int k = 0; k < nb; k++) e1.push_back(w[127 - 8*k -: 8]);
  endtask
  task automatic push2(input logic [63:0] w);
    f2.push_back(w);
    for (int k = 0; k < 4; k++) e2.push_back(w[63 - 16*k -: 16]);
  endtask

  // Show-ahead FIFO models: pop on require, head/empty visible from the next edge.
  always @(posedge clk) begin
    if (req0 === 1'b1 && f0.size() != 0) void'(f0.pop_front());
    if (req1 === 1'b1 && f1.size() != 0) void'(f1.pop_front());
    if (req2 === 1'b1 && f2.size() != 0) void'(f2.pop_front());
    empty0 <= (f0.size() == 0);
    data0  <= (f0.size() != 0) ? f0[0] : '0;
    empty1 <= (f1.size() == 0);
    data1  <= (f1.size() != 0) ? f1[0] : '0;
    empty2 <= (f2.size() == 0);
    data2  <= (f2.size() != 0) ? f2[0] : '0;
  end

  int en0_per = 250, en0_cnt = 0, en2_cnt = 0;
  always @(negedge clk) begin
    en0_cnt = (en0_cnt + 1 >= en0_per) ? 0 : en0_cnt + 1;
    en0     = (en0_cnt == 0);
    en2_cnt = (en2_cnt == 2) ? 0 : en2_cnt + 1;
    en2     = (en2_cnt == 0);
  end

  // Chip model: answers an outstanding beat 5 cycles later while enabled.
  logic chip_on = 1'b1;
  int   ack_dly = 0;
  always @(negedge clk) begin
    if (sh1 === ack1) ack_dly = 0;
    else if (chip_on) begin
      ack_dly++;
      if (ack_dly == 5) begin
        ack1    = sh1;
        ack_dly = 0;
      end
    end
  end

  logic sh0_p = 1'b0, sh1_p = 1'b0, sh2_p = 1'b0;
  int   tog0 = 0, tog1 = 0, tog2 = 0, nreq0 = 0, nreq1 = 0, nreq2 = 0, nterr1 = 0;
  always @(posedge clk) begin
    #1;
    if (!(rst_n && rst0_n)) sh0_p = sh0;
    else begin
      if (req0) nreq0++;
      if (sh0 !== sh0_p) begin
        sh0_p = sh0;
        tog0++;
        chk("dut0 beat queued", 64'(e0.size() != 0), 64'd1);
        if (e0.size() != 0) chk("dut0 tx", 64'(tx0), 64'(e0.pop_front()));
      end
    end
    if (!rst_n) begin
      sh1_p = sh1;
      sh2_p = sh2;
    end else begin
      if (req1) nreq1++;
      if (req2) nreq2++;
      if (terr1) nterr1++;
      if (sh1 !== sh1_p) begin
        sh1_p = sh1;
        tog1++;
        chk("dut1 beat queued", 64'(e1.size() != 0), 64'd1);
        if (e1.size() != 0) chk("dut1 tx", 64'(tx1), 64'(e1.pop_front()));
      end
      if (sh2 !== sh2_p) begin
        sh2_p = sh2;
        tog2++;
        chk("dut2 beat queued", 64'(e2.size() != 0), 64'd1);
        if (e2.size() != 0) chk("dut2 tx", 64'(tx2), 64'(e2.pop_front()));
      end
    end
  end

  initial begin
    int c0, c1, nb;
    repeat (3) @(posedge clk);
    #2;
    chk("reset shakehand", 64'(sh0), 64'd0);
    chk("reset tx", 64'(tx0), 64'd0);
    chk("reset busy", 64'(busy0), 64'd0);
    chk("reset require", 64'(req0), 64'd0);
    chk("reset timeout_err", 64'(terr0), 64'd0);
    chk("reset sent_cnt", 64'(sent0), 64'd0);
    chk("reset err_cnt", 64'(errc0), 64'd0);
    chk("reset busy dut1", 64'(busy1), 64'd0);
    rst_n = 1'b1;

    // Open loop, en every 250 cycles, one block
    push0(128'h00112233_44556677_8899AABB_CCDDEEFF, 16);
    for (int i = 0; i < 10 && empty0; i++) begin @(posedge clk); #2; end
    c0 = cyc;
    for (int i = 0; i < 10 && !req0; i++) begin @(posedge clk); #2; end
    chk("require latency", 64'(cyc - c0), 64'd1);
    for (int i = 0; i < 5000 && tog0 < 16; i++) begin @(posedge clk); #2; end
    chk("t1 beats", 64'(tog0), 64'd16);
    chk("t1 busy after last", 64'(busy0), 64'd0);
    chk("t1 sent_cnt", 64'(sent0), 64'd1);
    chk("t1 require pulses", 64'(nreq0), 64'd1);

    // en held high: beats on consecutive cycles
    en0_per = 1;
    @(posedge clk); #2;
    push0(128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F, 16);
    push0(128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0, 16);
    for (int i = 0; i < 50 && tog0 < 17; i++) begin @(posedge clk); #2; end
    c1 = cyc;
    for (int i = 0; i < 50 && tog0 < 32; i++) begin @(posedge clk); #2; end
    chk("t2 block span", 64'(cyc - c1), 64'd15);
    for (int i = 0; i < 60 && tog0 < 48; i++) begin @(posedge clk); #2; end
    chk("t2 beats", 64'(tog0), 64'd48);
    chk("t2 sent_cnt", 64'(sent0), 64'd3);
    chk("t2 require pulses", 64'(nreq0), 64'd3);

    // Reset pulse after 7 beats of a block
    push0(128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 7);
    for (int i = 0; i < 50 && tog0 < 55; i++) begin @(posedge clk); #2; end
    chk("t3 beats before reset", 64'(tog0), 64'd55);
    rst0_n = 1'b0;
    nb = nreq0;
    @(posedge clk); #2;
    chk("t3 shakehand", 64'(sh0), 64'd0);
    chk("t3 tx", 64'(tx0), 64'd0);
    chk("t3 busy", 64'(busy0), 64'd0);
    chk("t3 require", 64'(req0), 64'd0);
    chk("t3 timeout_err", 64'(terr0), 64'd0);
    chk("t3 sent_cnt", 64'(sent0), 64'd0);
    chk("t3 err_cnt", 64'(errc0), 64'd0);
    rst0_n = 1'b1;
    repeat (3) begin @(posedge clk); #2; end
    chk("t3 no require after reset", 64'(nreq0), 64'(nb));
    push0(128'h13579BDF_2468ACE0_FEDCBA98_76543210, 16);
    for (int i = 0; i < 60 && tog0 < 71; i++) begin @(posedge clk); #2; end
    chk("t3 beats after reset", 64'(tog0), 64'd71);
    chk("t3 sent after reset", 64'(sent0), 64'd1);
    chk("t3 busy after block", 64'(busy0), 64'd0);

    // 64/16 open loop, three queued blocks
    push2(64'h0123_4567_89AB_CDEF);
    push2(64'hFEDC_BA98_7654_3210);
    push2(64'hA5A5_5A5A_0F0F_F0F0);
    for (int i = 0; i < 400 && tog2 < 12; i++) begin @(posedge clk); #2; end
    chk("t4 beats", 64'(tog2), 64'd12);
    chk("t4 require pulses", 64'(nreq2), 64'd3);
    chk("t4 sent_cnt", 64'(sent2), 64'd3);
    chk("t4 fifo drained", 64'(f2.size()), 64'd0);

    // Closed loop, full block
    push1(128'h00112233_44556677_8899AABB_CCDDEEFF, 16);
    for (int i = 0; i < 500 && sent1 < 1; i++) begin @(posedge clk); #2; end
    chk("t5 sent_cnt", 64'(sent1), 64'd1);
    chk("t5 beats", 64'(tog1), 64'd16);
    chk("t5 no timeout", 64'(nterr1), 64'd0);
    chk("t5 busy", 64'(busy1), 64'd0);

    // Closed loop, chip silent after beat 3 -> abort after 20 cycles
    push1(128'h8899AABB_CCDDEEFF_00112233_44556677, 4);
    for (int i = 0; i < 200 && tog1 < 20; i++) begin @(posedge clk); #2; end
    chip_on = 1'b0;
    c1 = cyc;
    chk("t6 beats before stall", 64'(tog1), 64'd20);
    for (int i = 0; i < 100 && !terr1; i++) begin @(posedge clk); #2; end
    chk("t6 timeout latency", 64'(cyc - c1), 64'd20);
    chk("t6 err_cnt", 64'(errc1), 64'd1);
    chk("t6 sent_cnt", 64'(sent1), 64'd1);
    chk("t6 busy", 64'(busy1), 64'd0);
    @(posedge clk); #2;
    chk("t6 timeout pulse width", 64'(terr1), 64'd0);
    chk("t6 timeout count", 64'(nterr1), 64'd1);

    // Next block restarts from beat 0
    chip_on = 1'b1;
    for (int i = 0; i < 20 && ack1 !== sh1; i++) begin @(posedge clk); #2; end
    push1(128'hCAFEBABE_01020304_05060708_090A0B0C, 16);
    for (int i = 0; i < 500 && sent1 < 2; i++) begin @(posedge clk); #2; end
    chk("t7 sent_cnt", 64'(sent1), 64'd2);
    chk("t7 err_cnt", 64'(errc1), 64'd1);
    chk("t7 beats", 64'(tog1), 64'd36);

    repeat (5) @(posedge clk);
    #2;
    chk("dut0 scoreboard empty", 64'(e0.size()), 64'd0);
    chk("dut1 scoreboard empty", 64'(e1.size()), 64'd0);
    chk("dut2 scoreboard empty", 64'(e2.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
